// File: rtl/adder_pkg.sv
// ============================================================================
// Module : adder_pkg
// Shared constants and helpers for the adder family.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package adder_pkg;

  localparam int DEFAULT_WIDTH = 32;

  // Ceiling log2, floored at 1 so a 1-bit id is always available.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    if (result < 1) begin
      result = 1;
    end
    return result;
  endfunction

  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

`default_nettype wire

// File: rtl/adder_share_arbiter_if.sv
// ============================================================================
// Module : adder_share_arbiter_if
// Request and result handshake bundle for the shared adder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface adder_share_arbiter_if #(
  parameter int WIDTH   = adder_pkg::DEFAULT_WIDTH,
  parameter int NUM_REQ = 4
);
  import adder_pkg::*;

  localparam int ID_W = clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       req_cin;
  logic                     res_valid;
  logic                     res_ready;
  logic [WIDTH-1:0]         res_sum;
  logic                     res_cout;
  logic                     res_ovf;
  logic [ID_W-1:0]          res_id;

  modport master (
    output req_valid, req_a, req_b, req_cin, res_ready,
    input  req_ready, res_valid, res_sum, res_cout, res_ovf, res_id
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin, res_ready,
    output req_ready, res_valid, res_sum, res_cout, res_ovf, res_id
  );

endinterface

`default_nettype wire

// File: rtl/adder_share_arbiter_rr_arbiter.sv
// ============================================================================
// Module : rr_arbiter
// Combinational round-robin grant starting the search at i_ptr.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = adder_pkg::clog2(NUM_REQ)
) (
  input  wire logic [NUM_REQ-1:0] i_req,
  input  wire logic [ID_W-1:0]    i_ptr,
  input  wire logic               i_enable,
  output logic      [NUM_REQ-1:0] o_grant,
  output logic      [ID_W-1:0]    o_idx
);

  always_comb begin : p_search
    int  v_j;
    logic v_found;
    o_grant = '0;
    o_idx   = '0;
    v_found = 1'b0;
    v_j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      v_j = int'(i_ptr) + k;
      if (v_j >= NUM_REQ) begin
        v_j = v_j - NUM_REQ;
      end
      if (i_enable && !v_found && i_req[v_j]) begin
        v_found      = 1'b1;
        o_grant[v_j] = 1'b1;
        o_idx        = v_j[ID_W-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/carry_select_adder.sv
// ============================================================================
// Module : carry_select_adder
// WIDTH-bit adder built from 4-bit carry-select blocks.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module carry_select_adder #(
  parameter int WIDTH = adder_pkg::DEFAULT_WIDTH
) (
  input  wire logic [WIDTH-1:0] i_a,
  input  wire logic [WIDTH-1:0] i_b,
  input  wire logic             i_cin,
  output logic      [WIDTH-1:0] o_sum,
  output logic                  o_cout
);

  localparam int BLK  = 4;
  localparam int NBLK = (WIDTH + BLK - 1) / BLK;

  logic [NBLK:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar k = 0; k < NBLK; k++) begin : g_blk
    localparam int LO = k * BLK;
    localparam int BW = ((WIDTH - LO) < BLK) ? (WIDTH - LO) : BLK;

    logic [BW:0] w_s0;
    logic [BW:0] w_s1;

    // Both carry hypotheses are precomputed; the incoming carry only selects.
    assign w_s0 = {1'b0, i_a[LO +: BW]} + {1'b0, i_b[LO +: BW]};
    assign w_s1 = {1'b0, i_a[LO +: BW]} + {1'b0, i_b[LO +: BW]} + (BW+1)'(1);

    assign o_sum[LO +: BW] = w_c[k] ? w_s1[BW-1:0] : w_s0[BW-1:0];
    assign w_c[k+1]        = w_c[k] ? w_s1[BW]     : w_s0[BW];
  end

  assign o_cout = w_c[NBLK];

endmodule

`default_nettype wire

// File: rtl/adder_share_arbiter.sv
// ============================================================================
// Module : adder_share_arbiter
// Round-robin sharing of one carry_select_adder with a 1-deep result register.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module adder_share_arbiter
  import adder_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int NUM_REQ = 4
) (
  input  wire logic           clk,
  input  wire logic           rst,
  adder_share_arbiter_if.slave bus
);

  localparam int ID_W = clog2(NUM_REQ);

  logic [ID_W-1:0]    r_ptr;
  logic               r_res_valid;
  logic [WIDTH-1:0]   r_res_sum;
  logic               r_res_cout;
  logic               r_res_ovf;
  logic [ID_W-1:0]    r_res_id;

  logic               w_can_accept;
  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_idx;
  logic               w_xfer;
  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;
  logic               w_cin;
  logic [WIDTH-1:0]   w_sum;
  logic               w_cout;
  logic               w_ovf;

  // Granting is suppressed during reset so nothing appears accepted.
  assign w_can_accept = (!r_res_valid || bus.res_ready) && !rst;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .i_req    (bus.req_valid),
    .i_ptr    (r_ptr),
    .i_enable (w_can_accept),
    .o_grant  (w_grant),
    .o_idx    (w_idx)
  );

  assign w_xfer        = |w_grant;
  assign bus.req_ready = w_grant;

  assign w_a   = bus.req_a[int'(w_idx)*WIDTH +: WIDTH];
  assign w_b   = bus.req_b[int'(w_idx)*WIDTH +: WIDTH];
  assign w_cin = bus.req_cin[w_idx];

  carry_select_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .i_a    (w_a),
    .i_b    (w_b),
    .i_cin  (w_cin),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  assign w_ovf = add_ovf(w_a[WIDTH-1], w_b[WIDTH-1], w_sum[WIDTH-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr       <= '0;
      r_res_valid <= 1'b0;
      r_res_sum   <= '0;
      r_res_cout  <= 1'b0;
      r_res_ovf   <= 1'b0;
      r_res_id    <= '0;
    end else if (w_xfer) begin
      r_res_valid <= 1'b1;
      r_res_sum   <= w_sum;
      r_res_cout  <= w_cout;
      r_res_ovf   <= w_ovf;
      r_res_id    <= w_idx;
      // Explicit wrap keeps the pointer legal for non-power-of-two counts.
      r_ptr       <= (w_idx == ID_W'(NUM_REQ-1)) ? '0 : w_idx + ID_W'(1);
    end else if (bus.res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

  assign bus.res_valid = r_res_valid;
  assign bus.res_sum   = r_res_sum;
  assign bus.res_cout  = r_res_cout;
  assign bus.res_ovf   = r_res_ovf;
  assign bus.res_id    = r_res_id;

endmodule

`default_nettype wire

// File: tb/tb_adder_share_arbiter.sv
// ============================================================================
// Module : tb_adder_share_arbiter
// Directed self-checking bench for adder_share_arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_adder_share_arbiter;

  localparam int WIDTH   = 32;
  localparam int NUM_REQ = 4;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;

  adder_share_arbiter_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) bus ();

  adder_share_arbiter #(
    .WIDTH   (WIDTH),
    .NUM_REQ (NUM_REQ)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total = n_total + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic cin);
    bus.req_a[idx*WIDTH +: WIDTH] = a;
    bus.req_b[idx*WIDTH +: WIDTH] = b;
    bus.req_cin[idx]              = cin;
  endtask

  task automatic chk_res(input string tag, input logic [31:0] sum, input logic cout,
                         input logic ovf, input logic [1:0] id);
    chk_eq({tag, "_valid"}, 64'(bus.res_valid), 64'd1);
    chk_eq({tag, "_sum"},   64'(bus.res_sum),   64'(sum));
    chk_eq({tag, "_cout"},  64'(bus.res_cout),  64'(cout));
    chk_eq({tag, "_ovf"},   64'(bus.res_ovf),   64'(ovf));
    chk_eq({tag, "_id"},    64'(bus.res_id),    64'(id));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_total       = 0;
    n_bad         = 0;
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_cin   = '0;
    bus.res_ready = 1'b0;

    // Reset state, with requests presented that must not be accepted.
    bus.req_valid = 4'hF;
    step();
    step();
    chk_eq("rst_rdy",   64'(bus.req_ready), 64'h0);
    chk_eq("rst_valid", 64'(bus.res_valid), 64'h0);
    chk_eq("rst_sum",   64'(bus.res_sum),   64'h0);
    chk_eq("rst_cout",  64'(bus.res_cout),  64'h0);
    chk_eq("rst_ovf",   64'(bus.res_ovf),   64'h0);
    chk_eq("rst_id",    64'(bus.res_id),    64'h0);
    bus.req_valid = '0;
    rst = 1'b0;

    // Positive overflow from requester 0.
    set_req(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    bus.req_valid = 4'b0001;
    bus.res_ready = 1'b1;
    #1 chk_eq("t1_rdy", 64'(bus.req_ready), 64'h1);
    step();
    bus.req_valid = '0;
    chk_res("t1", 32'h8000_0000, 1'b0, 1'b1, 2'd0);

    // Restart the pointer at 0, then all requesters continuously valid.
    rst = 1'b1;
    #1 chk_eq("rst2_valid", 64'(bus.res_valid), 64'h0);
    rst = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      set_req(i, 32'(i * 16), 32'h1, 1'b0);
    end
    bus.req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      #1 chk_eq("rr_rdy", 64'(bus.req_ready), 64'(1 << (k % 4)));
      step();
      chk_eq("rr_valid", 64'(bus.res_valid), 64'd1);
      chk_eq("rr_id",    64'(bus.res_id),    64'(k % 4));
      chk_eq("rr_sum",   64'(bus.res_sum),   64'((k % 4) * 16 + 1));
    end

    // Negative overflow result, then held under backpressure.
    bus.req_valid = '0;
    set_req(1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    bus.req_valid = 4'b0010;
    #1 chk_eq("bp_rdy0", 64'(bus.req_ready), 64'h2);
    step();
    bus.req_valid = '0;
    chk_res("bp", 32'h7FFF_FFFF, 1'b1, 1'b1, 2'd1);
    bus.res_ready = 1'b0;
    set_req(2, 32'h5, 32'h6, 1'b1);
    bus.req_valid = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      #1 chk_eq("bp_rdy", 64'(bus.req_ready), 64'h0);
      step();
    end
    chk_res("bp_hold", 32'h7FFF_FFFF, 1'b1, 1'b1, 2'd1);
    bus.res_ready = 1'b1;
    #1 chk_eq("bp_release_rdy", 64'(bus.req_ready), 64'h4);
    step();
    bus.req_valid = '0;
    chk_res("bp_new", 32'h0000_000C, 1'b0, 1'b0, 2'd2);

    // Pointer at 3: requester 3 wins over 1, then 1 (zero sum with carry).
    set_req(1, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1);
    set_req(3, 32'h1, 32'h2, 1'b0);
    bus.req_valid = 4'b1010;
    #1 chk_eq("ord_rdy3", 64'(bus.req_ready), 64'h8);
    step();
    chk_res("ord3", 32'h3, 1'b0, 1'b0, 2'd3);
    bus.req_valid = 4'b0010;
    #1 chk_eq("ord_rdy1", 64'(bus.req_ready), 64'h2);
    step();
    bus.req_valid = '0;
    chk_res("ord1", 32'h0, 1'b1, 1'b0, 2'd1);
    step();
    chk_eq("drain_valid", 64'(bus.res_valid), 64'h0);

    // Asynchronous reset with a pending result.
    bus.res_ready = 1'b0;
    bus.req_valid = 4'b0100;
    step();
    bus.req_valid = '0;
    chk_eq("ar_pending", 64'(bus.res_valid), 64'h1);
    #2 rst = 1'b1;
    #1 chk_eq("ar_valid", 64'(bus.res_valid), 64'h0);
    step();
    rst = 1'b0;
    set_req(0, 32'h10, 32'h20, 1'b0);
    bus.req_valid = 4'b1001;
    bus.res_ready = 1'b1;
    #1 chk_eq("ar_rdy", 64'(bus.req_ready), 64'h1);
    step();
    bus.req_valid = '0;
    chk_res("ar_res", 32'h30, 1'b0, 1'b0, 2'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Shares one carry_select_adder instance (WIDTH bits) between NUM_REQ requesters using round-robin arbitration.
- Each requester presents a, b and cin with a valid/ready handshake.
- The winning operands pass through the adder and are captured in a 1-deep output register, tagged with the requester id and signed-overflow flag.
- Sits between the requesting units and any downstream consumer that applies backpressure via res_ready.

Parameters:
WIDTH, 32, operand/sum width passed to carry_select_adder
NUM_REQ, 4, number of requesters (>=2)
ID_W, $clog2(NUM_REQ), derived localparam, requester id width (not overridable)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
req_a  in  NUM_REQ*WIDTH  flattened operand A, requester i at [i*WIDTH +: WIDTH]
req_b  in  NUM_REQ*WIDTH  flattened operand B, same packing
req_cin  in  NUM_REQ  per-requester carry-in
res_valid  out  1  result register holds a valid result
res_ready  in  1  consumer accepts result
res_sum  out  WIDTH  registered sum
res_cout  out  1  registered carry-out
res_ovf  out  1  registered signed overflow
res_id  out  ID_W  index of requester that produced the result

Behaviour:
- Reset, asynchronous, takes effect immediately:
  - res_valid=0, res_sum=0, res_cout=0, res_ovf=0, res_id=0, rr pointer=0.
  - req_ready forced to 0 while rst=1.
- can_accept = !res_valid || res_ready.
- Grant, combinational:
  - If can_accept and any req_valid, grant the first valid index found searching ptr, ptr+1, ... mod NUM_REQ.
  - req_ready = grant, always one-hot or zero.
  - req_ready may depend on req_valid. req_valid must not depend on req_ready.
- Transfer: req_valid[i] && req_ready[i] at rising edge k.
  - Operands of i are muxed into the adder combinationally; sum/cout are registered at edge k.
  - res_valid=1 and res_id=i after edge k (latency 1 cycle).
  - ptr <= (i+1) mod NUM_REQ at edge k. ptr is unchanged when there is no transfer.
- Overflow: res_ovf = (a[W-1]==b[W-1]) && (sum[W-1]!=a[W-1]), computed on the granted operands and registered together with the sum.
- Output handshake:
  - res_* stay stable while res_valid && !res_ready.
  - On res_ready && res_valid with no new grant, res_valid <= 0.
  - Simultaneous drain and grant in the same cycle: new result loads and res_valid stays 1. Throughput is 1 result/cycle.
- Backpressure: res_valid && !res_ready -> all req_ready=0. No request is lost, because a requester holds its operands until accepted.
- Requests that drop req_valid before a grant are simply not served; there is no internal request queue.
- Unused bit patterns: ptr is always < NUM_REQ. A non-power-of-two NUM_REQ wraps explicitly to 0.
- Reset mid-operation: a pending result is discarded and arbitration restarts from index 0.

Decomposition:
- Shared package/header adder_pkg:
  - default WIDTH=32.
  - clog2 helper for ID_W.
  - overflow-flag function reused by other adder blocks.
- Sub-module rr_arbiter: inputs req, ptr, enable; outputs one-hot grant and encoded index. Purely combinational.
- The ptr register lives in adder_share_arbiter. The existing carry_select_adder is instantiated unchanged.

Test Plan:
- Only req 0 valid: a=7FFFFFFF, b=00000001, cin=0, res_ready=1 -> one cycle later res_valid=1, sum=80000000, cout=0, ovf=1, id=0.
- Req 0..3 valid continuously, res_ready=1 -> grants in order 0,1,2,3,0, one per cycle; res_id follows one cycle later; no bubbles.
- Hold res_ready=0 with a result pending (a=80000000, b=FFFFFFFF) -> res_sum=7FFFFFFF, cout=1, ovf=1 held stable and req_ready=0 for 5 cycles. Raising res_ready -> new grant accepted in the same cycle.
- After a grant to req 2, assert req 1 and req 3 -> req 3 granted first, then req 1.
- Req 1: a=00000000, b=FFFFFFFF, cin=1 -> sum=00000000, cout=1, ovf=0, id=1.
- Assert rst asynchronously mid-cycle with res_valid=1 -> res_valid=0 without waiting for a clock edge. After release, req 0 and req 3 both valid -> req 0 granted.
